// File: rtl/sparse_ia_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sparse_ia_enc_pkg
// Description : Shared defaults, FSM state encoding and the activation
//               saturation helper for the sparse IA encoder.
//               Contents:
//                 DEF_CHANNEL, DEF_IN_W, DEF_OUT_W, DEF_MAX_LEN, DEF_LEN_W
//                 state_t  : S_IDLE / S_SCAN / S_MARK
//                 saturate : clamp a DEF_IN_W signed value to DEF_OUT_W
// Revision    : 1.0 - initial release
// ============================================================================
package sparse_ia_enc_pkg;

    localparam int DEF_CHANNEL = 32;
    localparam int DEF_IN_W    = 17;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_MAX_LEN = 1200;
    localparam int DEF_LEN_W   = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_MARK = 2'd2
    } state_t;

    // Clamp to the signed OUT_W range; the bounds are sign-extended to IN_W
    // so the comparisons are done at full input precision.
    function automatic logic signed [DEF_OUT_W-1:0] saturate(
        input logic signed [DEF_IN_W-1:0] v
    );
        logic signed [DEF_IN_W-1:0] c_max;
        logic signed [DEF_IN_W-1:0] c_min;
        c_max = {{(DEF_IN_W-DEF_OUT_W+1){1'b0}}, {(DEF_OUT_W-1){1'b1}}};
        c_min = {{(DEF_IN_W-DEF_OUT_W+1){1'b1}}, {(DEF_OUT_W-1){1'b0}}};
        if (v > c_max) begin
            return {1'b0, {(DEF_OUT_W-1){1'b1}}};
        end else if (v < c_min) begin
            return {1'b1, {(DEF_OUT_W-1){1'b0}}};
        end else begin
            return v[DEF_OUT_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_ia_enc_prienc.sv
`default_nettype none
// ============================================================================
// Module      : sparse_ia_enc_prienc
// Description : Combinational lowest-set-bit priority encoder.
//               Ports:
//                 i_mask  [WIDTH]  candidate bits
//                 o_idx   [IDX_W]  index of the lowest set bit (0 if none)
//                 o_found          any bit set
// Revision    : 1.0 - initial release
// ============================================================================
module sparse_ia_enc_prienc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sparse_ia_encoder.sv
`default_nettype none
// ============================================================================
// Module      : sparse_ia_encoder
// Description : Compresses a dense pixel vector of CHANNEL signed activations
//               into a (value, channel-index) stream, one nonzero per beat,
//               with a running per-tile length and sticky overflow.
//               Ports:
//                 i_clk, i_rst           clock, async active-high reset
//                 i_valid/o_ready        pixel handshake (i_data, i_last_pixel)
//                 o_valid/i_ready        entry handshake
//                 o_data, o_c_idx        saturated value and its channel
//                 o_pix_end, o_tile_end  last beat of pixel / of tile
//                 o_null                 payload-free tile-closing beat
//                 o_len                  entries in tile incl. current beat
//                 o_overflow             tile exceeded MAX_LEN (sticky)
//               Build option: SPARSE_IA_ENC_RELU_EN - negative activations
//               map to zero and are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module sparse_ia_encoder
    import sparse_ia_enc_pkg::*;
#(
    parameter int CHANNEL = DEF_CHANNEL,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [CHANNEL*IN_W-1:0]    i_data,
    input  logic                       i_last_pixel,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [OUT_W-1:0]           o_data,
    output logic [$clog2(CHANNEL)-1:0] o_c_idx,
    output logic                       o_pix_end,
    output logic                       o_tile_end,
    output logic                       o_null,
    output logic [LEN_W-1:0]           o_len,
    output logic                       o_overflow
);

    localparam int c_idx_w = $clog2(CHANNEL);

    state_t                   r_state;
    state_t                   w_next;
    logic [CHANNEL*OUT_W-1:0] r_vals;
    logic [CHANNEL-1:0]       r_mask;
    logic                     r_last;
    logic [LEN_W-1:0]         r_len;
    logic                     r_overflow;

    logic [CHANNEL*OUT_W-1:0] w_vals;
    logic [CHANNEL-1:0]       w_nz;
    logic [c_idx_w-1:0]       w_idx;
    logic                     w_found;
    logic [CHANNEL-1:0]       w_mask_rest;
    logic                     w_full;

    // Per-channel transform and nonzero detection on the incoming pixel.
    for (genvar c = 0; c < CHANNEL; c++) begin : g_chan
        logic signed [IN_W-1:0]  w_in;
        logic signed [OUT_W-1:0] w_sat;
        assign w_in = i_data[c*IN_W +: IN_W];
`ifdef SPARSE_IA_ENC_RELU_EN
        assign w_sat = w_in[IN_W-1] ? '0 : saturate(w_in);
`else
        assign w_sat = saturate(w_in);
`endif
        assign w_vals[c*OUT_W +: OUT_W] = w_sat;
        assign w_nz[c]                  = |w_sat;
    end

    sparse_ia_enc_prienc #(
        .WIDTH (CHANNEL),
        .IDX_W (c_idx_w)
    ) u_prienc (
        .i_mask  (r_mask),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign w_mask_rest = r_mask & ~(CHANNEL'(1) << w_idx);
    assign w_full      = (r_len == LEN_W'(MAX_LEN));
    assign o_ready     = (r_state == S_IDLE);
    assign o_overflow  = r_overflow;
    // Null beats report the count without adding themselves.
    assign o_len       = (o_valid && !o_null) ? r_len + LEN_W'(1) : r_len;

    always_comb begin
        w_next     = r_state;
        o_valid    = 1'b0;
        o_null     = 1'b0;
        o_pix_end  = 1'b0;
        o_tile_end = 1'b0;
        o_data     = '0;
        o_c_idx    = '0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    // An all-zero closing pixel skips straight to its marker.
                    w_next = (w_nz == '0 && i_last_pixel) ? S_MARK : S_SCAN;
                end
            end
            S_SCAN: begin
                if (!w_found) begin
                    w_next = S_IDLE;
                end else if (w_full) begin
                    // Tile is full: this cycle drops the rest of the mask.
                    w_next = r_last ? S_MARK : S_IDLE;
                end else begin
                    o_valid    = 1'b1;
                    o_data     = r_vals[w_idx*OUT_W +: OUT_W];
                    o_c_idx    = w_idx;
                    o_pix_end  = (w_mask_rest == '0);
                    o_tile_end = o_pix_end && r_last;
                    if (i_ready && o_pix_end) begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_MARK: begin
                o_valid    = 1'b1;
                o_null     = 1'b1;
                o_pix_end  = 1'b1;
                o_tile_end = 1'b1;
                if (i_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_vals     <= '0;
            r_mask     <= '0;
            r_last     <= 1'b0;
            r_len      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_vals <= w_vals;
                        r_mask <= w_nz;
                        r_last <= i_last_pixel;
                    end
                end
                S_SCAN: begin
                    if (w_found && w_full) begin
                        r_mask     <= '0;
                        r_overflow <= 1'b1;
                    end else if (o_valid && i_ready) begin
                        r_mask <= w_mask_rest;
                        if (o_tile_end) begin
                            r_len      <= '0;
                            r_overflow <= 1'b0;
                        end else begin
                            r_len <= r_len + LEN_W'(1);
                        end
                    end
                end
                S_MARK: begin
                    if (i_ready) begin
                        r_len      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_ia_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparse_ia_encoder
// Description : Self-checking bench for sparse_ia_encoder: a table of directed
//               pixels plus hand-written sequences for backpressure, the
//               MAX_LEN overflow tile and reset during a scan.
//               Honours SPARSE_IA_ENC_RELU_EN in its expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_ia_encoder;

    localparam int CHANNEL = 32;
    localparam int IN_W    = 17;
    localparam int OUT_W   = 16;
    localparam int LEN_W   = 11;
    localparam int BW      = 4 + OUT_W + 5 + LEN_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    i_valid = 1'b0;
    logic                    o_ready;
    logic [CHANNEL*IN_W-1:0] i_data = '0;
    logic                    i_last_pixel = 1'b0;
    logic                    o_valid;
    logic                    i_ready = 1'b1;
    logic [OUT_W-1:0]        o_data;
    logic [4:0]              o_c_idx;
    logic                    o_pix_end;
    logic                    o_tile_end;
    logic                    o_null;
    logic [LEN_W-1:0]        o_len;
    logic                    o_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sparse_ia_encoder dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_last_pixel (i_last_pixel),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_c_idx      (o_c_idx),
        .o_pix_end    (o_pix_end),
        .o_tile_end   (o_tile_end),
        .o_null       (o_null),
        .o_len        (o_len),
        .o_overflow   (o_overflow)
    );

    typedef struct {
        logic [CHANNEL*IN_W-1:0] data;
        logic                    last;
        int                      nb;
        logic [3:0][OUT_W-1:0]   val;
        logic [3:0][4:0]         idx;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat_now();
        return {o_valid, o_null, o_pix_end, o_tile_end, o_data, o_c_idx, o_len};
    endfunction

    function automatic logic [BW-1:0] mk_beat(input logic v, input logic n, input logic p,
                                             input logic t, input logic [OUT_W-1:0] d,
                                             input logic [4:0] ix, input logic [LEN_W-1:0] ln);
        return {v, n, p, t, d, ix, ln};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!o_ready && t < 100) begin
            step();
            t++;
        end
        if (!o_ready) chk("wait_ready_timeout", 64'(o_ready), 64'(1));
    endtask

    // Leaves the bench one cycle after the accept edge.
    task automatic send_pixel(input logic [CHANNEL*IN_W-1:0] d, input logic last);
        wait_ready();
        i_valid      = 1'b1;
        i_data       = d;
        i_last_pixel = last;
        step();
        i_valid      = 1'b0;
        i_data       = '0;
        i_last_pixel = 1'b0;
    endtask

    function automatic logic [CHANNEL*IN_W-1:0] put(input logic [CHANNEL*IN_W-1:0] d,
                                                    input int ch, input int v);
        logic [CHANNEL*IN_W-1:0] r;
        r = d;
        r[ch*IN_W +: IN_W] = IN_W'(v);
        return r;
    endfunction

    initial begin
        logic [LEN_W-1:0]        exp_len;
        logic [CHANNEL*IN_W-1:0] d;
        logic [BW-1:0]           snap;
        logic                    stalled;
        int                      got;
        int                      cnt;
        int                      errs;
        int                      nulls;

        // ---------------- table ----------------
        for (int i = 0; i < 5; i++) begin
            tbl[i].data = '0; tbl[i].last = 1'b1; tbl[i].nb = 0;
            tbl[i].val = '0; tbl[i].idx = '0;
        end
        d = '0; d = put(d, 3, 5); d = put(d, 7, -2); d = put(d, 31, 40000);
        tbl[0].data = d;
`ifdef SPARSE_IA_ENC_RELU_EN
        tbl[0].nb = 2;
        tbl[0].val[0] = 16'd5;     tbl[0].idx[0] = 5'd3;
        tbl[0].val[1] = 16'h7FFF;  tbl[0].idx[1] = 5'd31;
`else
        tbl[0].nb = 3;
        tbl[0].val[0] = 16'd5;     tbl[0].idx[0] = 5'd3;
        tbl[0].val[1] = 16'hFFFE;  tbl[0].idx[1] = 5'd7;
        tbl[0].val[2] = 16'h7FFF;  tbl[0].idx[2] = 5'd31;
`endif
        // tbl[1]: all-zero closing pixel -> single null beat
        d = '0; d = put(d, 0, -40000); d = put(d, 1, 32767); d = put(d, 2, -32768);
        tbl[2].data = d; tbl[2].last = 1'b0;
`ifdef SPARSE_IA_ENC_RELU_EN
        tbl[2].nb = 1;
        tbl[2].val[0] = 16'h7FFF;  tbl[2].idx[0] = 5'd1;
`else
        tbl[2].nb = 3;
        tbl[2].val[0] = 16'h8000;  tbl[2].idx[0] = 5'd0;
        tbl[2].val[1] = 16'h7FFF;  tbl[2].idx[1] = 5'd1;
        tbl[2].val[2] = 16'h8000;  tbl[2].idx[2] = 5'd2;
`endif
        d = '0; d = put(d, 30, 1);
        tbl[3].data = d; tbl[3].nb = 1;
        tbl[3].val[0] = 16'd1;     tbl[3].idx[0] = 5'd30;
        d = '0; d = put(d, 5, 65535); d = put(d, 10, -1);
        tbl[4].data = d;
`ifdef SPARSE_IA_ENC_RELU_EN
        tbl[4].nb = 1;
        tbl[4].val[0] = 16'h7FFF;  tbl[4].idx[0] = 5'd5;
`else
        tbl[4].nb = 2;
        tbl[4].val[0] = 16'h7FFF;  tbl[4].idx[0] = 5'd5;
        tbl[4].val[1] = 16'hFFFF;  tbl[4].idx[1] = 5'd10;
`endif

        // ---------------- reset state ----------------
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_outputs", 64'(beat_now()), 64'(0));
        chk("reset_ovf_ready", 64'({o_overflow, o_ready}), 64'(2'b01));

        // ---------------- all-zero non-last pixel ----------------
        send_pixel('0, 1'b0);
        chk("zero_pix_busy", 64'({o_valid, o_ready}), 64'(2'b00));
        step();
        chk("zero_pix_ready", 64'({o_valid, o_ready}), 64'(2'b01));

        // ---------------- table-driven pixels ----------------
        exp_len = '0;
        for (int i = 0; i < 5; i++) begin
            send_pixel(tbl[i].data, tbl[i].last);
            if (tbl[i].nb == 0) begin
                chk($sformatf("tbl%0d_null", i), 64'(beat_now()),
                    64'(mk_beat(1, 1, 1, 1, '0, '0, exp_len)));
                step();
            end else begin
                for (int j = 0; j < tbl[i].nb; j++) begin
                    exp_len = exp_len + 1'b1;
                    chk($sformatf("tbl%0d_beat%0d", i, j), 64'(beat_now()),
                        64'(mk_beat(1, 0, j == tbl[i].nb - 1,
                                    (j == tbl[i].nb - 1) && tbl[i].last,
                                    tbl[i].val[j], tbl[i].idx[j], exp_len)));
                    step();
                end
            end
            if (tbl[i].last) exp_len = '0;
            chk($sformatf("tbl%0d_done", i), 64'({o_valid, o_ready}), 64'(2'b01));
        end

        // ---------------- backpressure on a 4-nonzero pixel ----------------
        d = '0; d = put(d, 0, 100); d = put(d, 9, 200); d = put(d, 17, 300); d = put(d, 31, 400);
        send_pixel(d, 1'b1);
        got = 0; stalled = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            logic [OUT_W-1:0] ev;
            logic [4:0]       ei;
            i_ready = (cyc % 2) == 1;
            case (got)
                0: begin ev = 16'd100; ei = 5'd0;  end
                1: begin ev = 16'd200; ei = 5'd9;  end
                2: begin ev = 16'd300; ei = 5'd17; end
                default: begin ev = 16'd400; ei = 5'd31; end
            endcase
            if (stalled) chk("bp_hold", 64'(beat_now()), 64'(snap));
            if (o_valid && i_ready) begin
                chk($sformatf("bp_beat%0d", got), 64'(beat_now()),
                    64'(mk_beat(1, 0, got == 3, got == 3, ev, ei, LEN_W'(got + 1))));
                got++;
                stalled = 1'b0;
            end else if (o_valid) begin
                snap    = beat_now();
                stalled = 1'b1;
            end
            step();
        end
        i_ready = 1'b1;
        chk("bp_count", 64'(got), 64'(4));
        chk("bp_done", 64'({o_valid, o_ready}), 64'(2'b01));

        // ---------------- overflow tile: 38 full pixels ----------------
        d = '0;
        for (int c = 0; c < CHANNEL; c++) d = put(d, c, c + 1);
        cnt = 0; errs = 0; nulls = 0;
        for (int p = 0; p < 38; p++) begin
            int pc;
            pc = 0;
            send_pixel(d, p == 37);
            for (int t = 0; t < 40 && !o_ready; t++) begin
                if (o_valid && o_null) begin
                    nulls++;
                    chk("ovf_null_beat", 64'({o_overflow, o_tile_end, o_data, o_c_idx, o_len}),
                        64'({1'b1, 1'b1, 16'd0, 5'd0, LEN_W'(1200)}));
                end else if (o_valid) begin
                    cnt++;
                    if (o_len != LEN_W'(cnt) || o_c_idx != 5'(pc) ||
                        o_data != OUT_W'(pc + 1) || o_overflow) errs++;
                    pc++;
                end
                step();
            end
        end
        chk("ovf_entries", 64'(cnt), 64'(1200));
        chk("ovf_entry_errs", 64'(errs), 64'(0));
        chk("ovf_nulls", 64'(nulls), 64'(1));
        d = '0; d = put(d, 4, 7);
        send_pixel(d, 1'b1);
        chk("after_ovf_beat", 64'({o_overflow, beat_now()}),
            64'({1'b0, mk_beat(1, 0, 1, 1, 16'd7, 5'd4, LEN_W'(1))}));
        step();

        // ---------------- reset mid-scan ----------------
        d = '0; d = put(d, 1, 11); d = put(d, 6, 22); d = put(d, 20, 33);
        i_ready = 1'b0;
        send_pixel(d, 1'b1);
        step();
        chk("mid_scan_valid", 64'({o_valid, o_data}), 64'({1'b1, 16'd11}));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", 64'({o_overflow, beat_now()}), 64'(0));
        chk("rst_async_ready", 64'(o_ready), 64'(1));
        step();
        rst = 1'b0;
        i_ready = 1'b1;
        step();
        chk("rst_release", 64'({o_valid, o_ready}), 64'(2'b01));
        d = '0; d = put(d, 2, 9);
        send_pixel(d, 1'b1);
        chk("post_rst_beat", 64'(beat_now()),
            64'(mk_beat(1, 0, 1, 1, 16'd9, 5'd2, LEN_W'(1))));
        step();
        chk("post_rst_done", 64'({o_valid, o_ready}), 64'(2'b01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
